// File: rtl/pattern_seq_pkg.sv
// Shared types for the pattern stream sequencer: FSM state encoding and default widths.
package pattern_seq_pkg;

    localparam int DEF_WORD_W = 20;
    localparam int DEF_CNT_W  = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRST  = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/pattern_stream_sequencer_if.sv
// Word-in / result-out handshakes of the pattern stream sequencer.
interface pattern_stream_sequencer_if
    import pattern_seq_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              in_keep_state;
    logic              res_valid;
    logic              res_ready;
    logic [CNT_W-1:0]  res_count;
    logic [CNT_W-1:0]  res_first_idx;
    logic              res_hit;

    // master: word producer and result consumer; slave: the sequencer
    modport master (
        output in_valid, in_word, in_keep_state, res_ready,
        input  in_ready, res_valid, res_count, res_first_idx, res_hit
    );
    modport slave (
        input  in_valid, in_word, in_keep_state, res_ready,
        output in_ready, res_valid, res_count, res_first_idx, res_hit
    );
endinterface

// File: rtl/pattern_seq_tagpipe.sv
// Delay line carrying {valid, bit index} for each driven bit so detector
// responses can be attributed to the bit that caused them.
module pattern_seq_tagpipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             tag_vld,
    input  logic [IDX_W-1:0] tag_idx,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx
);
    logic [DEPTH-1:0]            vld_pipe;
    logic [DEPTH-1:0][IDX_W-1:0] idx_pipe;

    always_ff @(posedge clk) begin
        if (clr) begin
            vld_pipe <= '0;
            idx_pipe <= '0;
        end else begin
            vld_pipe[0] <= tag_vld;
            idx_pipe[0] <= tag_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
        end
    end

    assign out_vld = vld_pipe[DEPTH-1];
    assign out_idx = idx_pipe[DEPTH-1];
endmodule

// File: rtl/pattern_stream_sequencer.sv
// Serialises accepted words into a pattern detector, counts its match pulses
// and returns a per-word result (count, first matching bit index).
module pattern_stream_sequencer
    import pattern_seq_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int DET_LATENCY = 1,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    pattern_stream_sequencer_if.slave   bus,
    output logic                        det_rst,
    output logic                        det_stream_in,
    input  logic                        det_found,
    output logic                        busy
);
    localparam int               DW         = (DET_LATENCY > 1) ? $clog2(DET_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(DET_LATENCY - 1);

    seq_state_e        state, state_nxt;
    logic [WORD_W-1:0] word;
    logic [CNT_W-1:0]  bit_idx;
    logic [DW-1:0]     drain_cnt;
    logic [CNT_W-1:0]  count, first_idx;
    logic              rst_q;
    logic              accept;
    logic              in_ready, res_valid, drst_out, stream_out;
    logic              tag_vld;
    logic [CNT_W-1:0]  tag_idx;

    assign accept = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        drst_out   = 1'b0;
        stream_out = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nxt = bus.in_keep_state ? SHIFT : DRST;
            end
            DRST: begin
                drst_out  = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                stream_out = word[bit_idx];
                if (bit_idx == LAST_IDX) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (bus.res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The detector is reset once on the cycle following our own reset.
    always_ff @(posedge clk) rst_q <= rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            word      <= '0;
            bit_idx   <= '0;
            drain_cnt <= '0;
            count     <= '0;
            first_idx <= '0;
        end else if (accept) begin
            word      <= bus.in_word;
            bit_idx   <= '0;
            drain_cnt <= '0;
            count     <= '0;
            first_idx <= '0;
        end else begin
            if (state == SHIFT) bit_idx   <= bit_idx + 1'b1;
            if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
            if (det_found && tag_vld) begin
                if (count == '0)     first_idx <= tag_idx;
                if (count != CNT_MAX) count    <= count + 1'b1;
            end
        end
    end

    pattern_seq_tagpipe #(.DEPTH(DET_LATENCY), .IDX_W(CNT_W)) u_tagpipe (
        .clk     (clk),
        .clr     (rst),
        .tag_vld (state == SHIFT),
        .tag_idx (bit_idx),
        .out_vld (tag_vld),
        .out_idx (tag_idx)
    );

    assign bus.in_ready      = in_ready;
    assign bus.res_valid     = res_valid;
    assign bus.res_count     = count;
    assign bus.res_first_idx = first_idx;
    assign bus.res_hit       = (count != '0);
    assign det_rst           = rst_q | drst_out;
    assign det_stream_in     = stream_out;
    assign busy              = (state != IDLE);
endmodule

// File: tb/tb_pattern_stream_sequencer.sv
// Random and directed words through the sequencer with a registered-bit stub
// detector, checked against a popcount / lowest-set-bit reference.
module tb_pattern_stream_sequencer;
    localparam int WORD_W = 20;
    localparam int CNT_W  = 5;
    localparam logic [WORD_W-1:0] SPEC_WORD = 20'b01101011111010011010;

    logic clk = 1'b0;
    logic rst;
    logic det_rst, det_stream_in, det_found, busy;
    int   n_vec = 0;
    int   n_err = 0;

    pattern_stream_sequencer_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

    pattern_stream_sequencer #(.WORD_W(WORD_W), .DET_LATENCY(1), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .det_rst       (det_rst),
        .det_stream_in (det_stream_in),
        .det_found     (det_found),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Stub detector: every 1 bit is reported as a match one cycle later.
    always_ff @(posedge clk) begin
        if (rst || det_rst) det_found <= 1'b0;
        else                det_found <= det_stream_in;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: one match per set bit, first match at the lowest set bit.
    function automatic void model(input logic [WORD_W-1:0] w, output int cnt, output int idx);
        cnt = 0;
        idx = 0;
        for (int i = 0; i < WORD_W; i++)
            if (w[i]) begin
                if (cnt == 0) idx = i;
                if (cnt < (1 << CNT_W) - 1) cnt++;
            end
    endfunction

    // Called at a negedge with the sequencer idle; returns at a negedge, idle again.
    task automatic run_word(input logic [WORD_W-1:0] w, input bit keep, input int hold);
        int lat, drst_n, sh0, ecnt, eidx;
        bit bad;
        logic [WORD_W-1:0] cap;
        model(w, ecnt, eidx);
        sh0    = keep ? 1 : 2;
        lat    = 0;
        drst_n = 0;
        cap    = '0;
        chk("in_ready_idle", bus.in_ready, 1);
        bus.in_valid      = 1'b1;
        bus.in_word       = w;
        bus.in_keep_state = keep;
        bus.res_ready     = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid      = 1'b0;
        bus.in_word       = WORD_W'($urandom);
        bus.in_keep_state = 1'($urandom);
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (det_rst) drst_n++;
            if (lat >= sh0 && lat < sh0 + WORD_W) cap[lat - sh0] = det_stream_in;
            if (bus.res_valid) break;
        end
        chk("latency", lat, keep ? 22 : 23);
        chk("serial", cap, w);
        chk("det_rst_pulses", drst_n, keep ? 0 : 1);
        chk("res_count", bus.res_count, ecnt);
        chk("res_first_idx", bus.res_first_idx, eidx);
        chk("res_hit", bus.res_hit, ecnt != 0);
        if (hold > 0) begin
            bad          = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_word  = WORD_W'($urandom);
            repeat (hold) begin
                @(negedge clk);
                if (!bus.res_valid || bus.in_ready || !busy || det_stream_in || det_rst ||
                    bus.res_count != CNT_W'(ecnt) || bus.res_first_idx != CNT_W'(eidx))
                    bad = 1'b1;
            end
            chk("backpressure_hold", bad, 0);
            bus.in_valid = 1'b0;
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        @(negedge clk);
        chk("post_handshake", {bus.res_valid, bus.in_ready, busy}, 3'b010);
    endtask

    task automatic mid_reset(input logic [WORD_W-1:0] w);
        bit seen;
        int drst_n;
        bus.in_valid      = 1'b1;
        bus.in_word       = w;
        bus.in_keep_state = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("bit7_driven", det_stream_in, w[7]);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_state", {bus.res_valid, bus.in_ready, busy, det_rst}, 4'b0101);
        seen   = 1'b0;
        drst_n = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1'b1;
            if (det_rst) drst_n++;
        end
        chk("midrst_no_result", seen, 0);
        chk("midrst_single_drst", drst_n, 0);
    endtask

    initial begin
        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_word       = '0;
        bus.in_keep_state = 1'b0;
        bus.res_ready     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {bus.in_ready, bus.res_valid, busy, det_rst, det_stream_in}, 5'b10010);
        chk("reset_result", {bus.res_count, bus.res_first_idx, bus.res_hit}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_drst_end", det_rst, 0);

        run_word(SPEC_WORD, 1'b0, 0);
        run_word(20'h00000, 1'b0, 0);
        run_word(20'hFFFFF, 1'b0, 0);
        run_word(SPEC_WORD, 1'b0, 10);
        run_word(WORD_W'($urandom), 1'b0, 0);
        run_word(WORD_W'($urandom), 1'b1, 0);
        mid_reset(WORD_W'($urandom));
        run_word(SPEC_WORD, 1'b0, 0);
        run_word(20'h80000, 1'b1, 0);
        for (int i = 0; i < 20; i++)
            run_word(WORD_W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
